// File: rtl/dft_pkg.sv
// Shared types and constants for the DDR ATPG capture-clock controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLD    = 3'd4
    } dft_cap_state_e;

    // Select codes understood by the downstream one-hot clock gating stage.
    localparam logic [1:0] DDR_SEL_NONE   = 2'b00;
    localparam logic [1:0] DDR_SEL_DFI    = 2'b01;
    localparam logic [1:0] DDR_SEL_DFICTL = 2'b10;
    localparam logic [1:0] DDR_SEL_APB    = 2'b11;

    // The shared down counter must hold both SETTLE_CYC-1 and a clamped pulse count minus one.
    function automatic int ctr_width(input int cnt_w, input int settle_cyc);
        int w_s;
        w_s = $clog2(settle_cyc);
        if (w_s < 1) begin
            w_s = 1;
        end
        return (cnt_w > w_s) ? cnt_w : w_s;
    endfunction

endpackage

// File: rtl/dft_cap_down_counter.sv
// Loadable down counter with zero flag, shared by the settle and capture phases.
// Latency: load/decrement visible one clk after the request; zero flag decodes the register.
// Backpressure: none; load has priority over decrement, decrement saturates at zero.
// Ports: clk_i/rst_i (sync, active-high), load_i + load_val_i, dec_i, zero_o.
module dft_cap_down_counter #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dft_ddr_capture_ctrl.sv
// Sequences shift -> settle -> capture -> hold per scan pattern and drives the DDR capture clock select.
// Latency: first capture cycle SETTLE_CYC+1 clk after scan_enable drops; all outputs registered.
// Backpressure: config accepted (cfg_ready_o) only in IDLE/ARMED; cfg_valid_i is held off elsewhere.
// Ports: clk_i, rst_i, scan_mode_i, scan_enable_i, cfg_valid_i/cfg_ready_o, cfg_clk_sel_i,
//        cfg_pulse_cnt_i, ddr_clk_sel_o, cap_active_o, pattern_done_o, busy_o.
module dft_ddr_capture_ctrl
    import dft_pkg::*;
#(
    parameter int CNT_W      = 3,
    parameter int MAX_PULSES = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scan_mode_i,
    input  logic             scan_enable_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [1:0]       cfg_clk_sel_i,
    input  logic [CNT_W-1:0] cfg_pulse_cnt_i,
    output logic [1:0]       ddr_clk_sel_o,
    output logic             cap_active_o,
    output logic             pattern_done_o,
    output logic             busy_o
);

    localparam int               CTR_W       = ctr_width(CNT_W, SETTLE_CYC);
    localparam logic [CTR_W-1:0] SETTLE_LOAD = CTR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_PULSES);

    dft_cap_state_e   state_q, state_d;
    logic             se_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_q;

    logic             cfg_ready_q;
    logic [1:0]       ddr_clk_sel_q;
    logic             cap_active_q;
    logic             pattern_done_q;
    logic             busy_q;

    logic             done_d;
    logic             ctr_load;
    logic [CTR_W-1:0] ctr_val;
    logic             ctr_dec;
    logic             ctr_zero;

    logic se_fall;
    logic cfg_xfer;
    logic cap_ok;

    assign se_fall  = se_q & ~scan_enable_i;
    assign cfg_xfer = cfg_valid_i & cfg_ready_q;
    // A pattern with no clock selected or zero pulses skips CAPTURE but still completes.
    assign cap_ok   = (sel_q != DDR_SEL_NONE) && (cnt_q != '0);

    dft_cap_down_counter #(.W(CTR_W)) u_ctr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ctr_load),
        .load_val_i (ctr_val),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        ctr_load = 1'b0;
        ctr_val  = '0;
        ctr_dec  = 1'b0;
        if (!scan_mode_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (se_fall) begin
                        state_d  = ST_SETTLE;
                        ctr_load = 1'b1;
                        ctr_val  = SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (scan_enable_i) begin
                        state_d = ST_ARMED;
                    end else if (!ctr_zero) begin
                        ctr_dec = 1'b1;
                    end else if (cap_ok) begin
                        // Counter runs cnt_q-1 .. 0, giving exactly cnt_q CAPTURE cycles.
                        state_d  = ST_CAPTURE;
                        ctr_load = 1'b1;
                        ctr_val  = CTR_W'(cnt_q) - CTR_W'(1);
                    end else begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (scan_enable_i) begin
                        state_d = ST_ARMED;
                    end else if (!ctr_zero) begin
                        ctr_dec = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (scan_enable_i) begin
                        state_d = ST_ARMED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            se_q           <= 1'b0;
            sel_q          <= DDR_SEL_NONE;
            cnt_q          <= '0;
            cfg_ready_q    <= 1'b1;
            ddr_clk_sel_q  <= DDR_SEL_NONE;
            cap_active_q   <= 1'b0;
            pattern_done_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            se_q    <= scan_enable_i;
            if (cfg_xfer) begin
                sel_q <= cfg_clk_sel_i;
                cnt_q <= (cfg_pulse_cnt_i > MAX_CNT) ? MAX_CNT : cfg_pulse_cnt_i;
            end
            cfg_ready_q    <= (state_d == ST_IDLE) || (state_d == ST_ARMED);
            ddr_clk_sel_q  <= (state_d == ST_CAPTURE) ? sel_q : DDR_SEL_NONE;
            cap_active_q   <= (state_d == ST_CAPTURE);
            pattern_done_q <= done_d;
            busy_q         <= (state_d == ST_SETTLE) || (state_d == ST_CAPTURE) ||
                              (state_d == ST_HOLD);
        end
    end

    assign cfg_ready_o    = cfg_ready_q;
    assign ddr_clk_sel_o  = ddr_clk_sel_q;
    assign cap_active_o   = cap_active_q;
    assign pattern_done_o = pattern_done_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_dft_ddr_capture_ctrl.sv
// Self-checking bench for dft_ddr_capture_ctrl: table of patterns plus hand-written corner sequences.
// Latency: expectations queued per clk, compared #1 after each rising edge.
// Backpressure: exercises cfg_valid held while cfg_ready is low.
module tb_dft_ddr_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_mode;
    logic       scan_enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_clk_sel;
    logic [2:0] cfg_pulse_cnt;
    logic [1:0] ddr_clk_sel;
    logic       cap_active;
    logic       pattern_done;
    logic       busy;

    always #5 clk = ~clk;

    dft_ddr_capture_ctrl #(
        .CNT_W      (3),
        .MAX_PULSES (4),
        .SETTLE_CYC (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .scan_mode_i     (scan_mode),
        .scan_enable_i   (scan_enable),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_clk_sel_i   (cfg_clk_sel),
        .cfg_pulse_cnt_i (cfg_pulse_cnt),
        .ddr_clk_sel_o   (ddr_clk_sel),
        .cap_active_o    (cap_active),
        .pattern_done_o  (pattern_done),
        .busy_o          (busy)
    );

    // Output vector layout: {cfg_ready, busy, cap_active, pattern_done, ddr_clk_sel[1:0]}
    localparam logic [5:0] O_IDLE   = 6'b100000;
    localparam logic [5:0] O_SETTLE = 6'b010000;
    localparam logic [5:0] O_DONE   = 6'b010100;
    localparam logic [5:0] O_HOLD   = 6'b010000;

    function automatic logic [5:0] o_cap(input logic [1:0] s);
        return {1'b0, 1'b1, 1'b1, 1'b0, s};
    endfunction

    typedef struct {
        logic [5:0] v;
        string      tag;
    } exp_t;

    typedef struct {
        bit         cfg_en;
        bit         same;
        logic [1:0] sel;
        logic [2:0] cnt;
        logic [1:0] exp_sel;
        int         exp_caps;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit         late_cfg = 1'b0;
    logic [1:0] late_sel = 2'b00;
    logic [2:0] late_cnt = 3'd0;

    task automatic expect_o(input logic [5:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t       e;
        logic [5:0] act;
        @(posedge clk);
        #1;
        act = {cfg_ready, busy, cap_active, pattern_done, ddr_clk_sel};
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL no_expectation: got {rdy,busy,cap,done,sel}=%b", act);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got {rdy,busy,cap,done,sel}=%b want %b", e.tag, act, e.v);
            end
        end
    endtask

    task automatic drive_cfg(input logic [1:0] s, input logic [2:0] c);
        cfg_valid     = 1'b1;
        cfg_clk_sel   = s;
        cfg_pulse_cnt = c;
    endtask

    // Starts in ARMED with scan_enable high; ends back in ARMED after raising scan_enable.
    task automatic run_pattern(input logic [1:0] s, input int caps, input string tag);
        scan_enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expect_o(O_SETTLE, $sformatf("%s settle%0d", tag, k));
            step();
            if (k == 1) begin
                cfg_valid = late_cfg;
                if (late_cfg) begin
                    cfg_clk_sel   = late_sel;
                    cfg_pulse_cnt = late_cnt;
                end
            end
        end
        for (int k = 1; k <= caps; k++) begin
            expect_o(o_cap(s), $sformatf("%s capture%0d", tag, k));
            step();
        end
        expect_o(O_DONE, $sformatf("%s done_pulse", tag));
        step();
        expect_o(O_HOLD, $sformatf("%s hold", tag));
        step();
        scan_enable = 1'b1;
        expect_o(O_IDLE, $sformatf("%s armed_after_se_rise", tag));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{cfg_en: 1, same: 0, sel: 2'b01, cnt: 3'd2, exp_sel: 2'b01, exp_caps: 2};
        vecs[1] = '{cfg_en: 1, same: 0, sel: 2'b11, cnt: 3'd7, exp_sel: 2'b11, exp_caps: 4};
        vecs[2] = '{cfg_en: 1, same: 0, sel: 2'b00, cnt: 3'd3, exp_sel: 2'b00, exp_caps: 0};
        vecs[3] = '{cfg_en: 1, same: 1, sel: 2'b10, cnt: 3'd1, exp_sel: 2'b10, exp_caps: 1};
        vecs[4] = '{cfg_en: 1, same: 0, sel: 2'b01, cnt: 3'd0, exp_sel: 2'b01, exp_caps: 0};
        vecs[5] = '{cfg_en: 1, same: 0, sel: 2'b10, cnt: 3'd4, exp_sel: 2'b10, exp_caps: 4};
        vecs[6] = '{cfg_en: 0, same: 0, sel: 2'b00, cnt: 3'd0, exp_sel: 2'b10, exp_caps: 4};

        rst           = 1'b1;
        scan_mode     = 1'b0;
        scan_enable   = 1'b0;
        cfg_valid     = 1'b0;
        cfg_clk_sel   = 2'b00;
        cfg_pulse_cnt = 3'd0;

        expect_o(O_IDLE, "reset");
        step();
        expect_o(O_IDLE, "reset_held");
        step();
        rst         = 1'b0;
        scan_mode   = 1'b1;
        scan_enable = 1'b1;
        expect_o(O_IDLE, "enter_armed");
        step();

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].cfg_en && !vecs[i].same) begin
                drive_cfg(vecs[i].sel, vecs[i].cnt);
                expect_o(O_IDLE, $sformatf("vec%0d cfg", i));
                step();
                cfg_valid = 1'b0;
            end else if (vecs[i].cfg_en) begin
                drive_cfg(vecs[i].sel, vecs[i].cnt);
            end
            run_pattern(vecs[i].exp_sel, vecs[i].exp_caps, $sformatf("vec%0d", i));
        end

        // Abort after one of three capture cycles.
        drive_cfg(2'b01, 3'd3);
        expect_o(O_IDLE, "abort cfg");
        step();
        cfg_valid   = 1'b0;
        scan_enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expect_o(O_SETTLE, $sformatf("abort settle%0d", k));
            step();
        end
        expect_o(o_cap(2'b01), "abort capture1");
        step();
        scan_enable = 1'b1;
        expect_o(O_IDLE, "abort sel_cleared");
        step();
        expect_o(O_IDLE, "abort no_done");
        step();
        run_pattern(2'b01, 3, "after_abort");

        // scan_mode dropped mid-CAPTURE; config retained afterwards.
        scan_enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            expect_o(O_SETTLE, $sformatf("mode_drop settle%0d", k));
            step();
        end
        expect_o(o_cap(2'b01), "mode_drop capture1");
        step();
        scan_mode = 1'b0;
        expect_o(O_IDLE, "mode_drop idle");
        step();
        expect_o(O_IDLE, "mode_drop idle_stays");
        step();
        scan_mode   = 1'b1;
        scan_enable = 1'b1;
        expect_o(O_IDLE, "mode_restore armed");
        step();
        run_pattern(2'b01, 3, "cfg_retained");

        // Reset mid-SETTLE; config lost afterwards.
        scan_enable = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            expect_o(O_SETTLE, $sformatf("rst_mid settle%0d", k));
            step();
        end
        rst = 1'b1;
        expect_o(O_IDLE, "rst_mid_settle");
        step();
        rst         = 1'b0;
        scan_enable = 1'b1;
        expect_o(O_IDLE, "rst_release armed");
        step();
        run_pattern(2'b00, 0, "cfg_lost");

        // cfg_valid held through a pattern: no transfer until back in ARMED.
        drive_cfg(2'b01, 3'd1);
        expect_o(O_IDLE, "held cfg");
        step();
        cfg_valid = 1'b0;
        late_cfg  = 1'b1;
        late_sel  = 2'b11;
        late_cnt  = 3'd2;
        run_pattern(2'b01, 1, "held_valid");
        expect_o(O_IDLE, "held transfer");
        step();
        cfg_valid = 1'b0;
        late_cfg  = 1'b0;
        run_pattern(2'b11, 2, "post_hold_cfg");

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
